// File: rtl/bin_fact_if.sv
// ----------------------------------------------------------------------------
// bin_fact_if
// Purpose : Groups the operand/handshake signals of the bin_fact shift-add
//           fractional multiplier into one bundle.
// Signals : start   - active-high, level-sensitive load/restart
//           a       - 7-bit multiplicand, unsigned fraction 0.a[6]..a[0]
//           b       - 7-bit multiplier, same format as a
//           done    - high while product holds a finished result
//           product - 13-bit unsigned fraction, bits [13:1] of a*b
// Modports: master drives start/a/b and observes done/product;
//           slave is the multiplier side.
// ----------------------------------------------------------------------------
interface bin_fact_if;
   logic        start;
   logic [6:0]  a;
   logic [6:0]  b;
   logic        done;
   logic [12:0] product;

   modport master (
      output start,
      output a,
      output b,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output done,
      output product
   );
endinterface

// File: rtl/bin_fact.sv
// ----------------------------------------------------------------------------
// bin_fact
// Purpose : Sequential shift-add multiplier for two 7-bit unsigned binary
//           fractions. One multiplier bit is consumed per clock, LSB first,
//           into a 14-bit accumulator. After seven iterations the upper 13
//           bits of the exact product are presented (the LSB is truncated).
// Ports   : clk   - single clock, rising edge active
//           rst_n - asynchronous active-low reset, dominates everything
//           bus   - bin_fact_if.slave (start, a, b in; done, product out)
// ----------------------------------------------------------------------------
module bin_fact (
   input  logic      clk,
   input  logic      rst_n,
   bin_fact_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the last iteration; the edge that performs it also
   // publishes the result.
   localparam logic [2:0] LAST_ITER = 3'd6;

   state_t      r_state;
   state_t      w_nextState;

   logic [6:0]  r_opA;
   logic [6:0]  r_opB;
   logic [13:0] r_acc;
   logic [2:0]  r_count;
   logic [12:0] r_product;
   logic        r_done;

   logic        w_iterate;
   logic        w_finish;
   logic [7:0]  w_bExt;
   logic        w_bBit;
   logic [13:0] w_aExt;
   logic [13:0] w_addend;
   logic [13:0] w_accNext;

   // The multiplier is padded to 8 bits so the 3-bit counter can index it
   // over its full range without going out of bounds.
   assign w_bExt    = {1'b0, r_opB};
   assign w_bBit    = w_bExt[r_count];
   assign w_aExt    = {7'd0, r_opA};
   // Partial product for this iteration: a shifted up by the bit position.
   assign w_addend  = w_bBit ? (w_aExt << r_count) : 14'd0;
   // 127*127 fits in 14 bits, so the accumulator never overflows.
   assign w_accNext = r_acc + w_addend;

   // State register. start acts like an asynchronous load: its rising edge
   // (or any clock edge while it is held high) forces BUSY so a run always
   // begins from a clean slate, even if start is a short pulse between
   // clock edges. Reset still wins over start.
   always_ff @(posedge clk or negedge rst_n or posedge bus.start) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (bus.start) begin
         r_state <= BUSY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and datapath control. BUSY iterates every cycle and
   // leaves for DONE on the edge that completes the seventh iteration;
   // there is no early exit for zero operands so latency is fixed.
   always_comb begin
      w_nextState = r_state;
      w_iterate   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            w_nextState = IDLE;
         end
         BUSY: begin
            w_iterate = 1'b1;
            if (r_count == LAST_ITER) begin
               w_finish    = 1'b1;
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = DONE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath registers. While start is high the operands are recaptured
   // and all working state is cleared, so the result of an aborted run can
   // never leak into the next one. Operands are only sampled under start,
   // which makes later changes on a/b invisible to a run in progress or
   // a held result. product stays 0 until the final edge so partial sums
   // are never visible on the outputs.
   always_ff @(posedge clk or negedge rst_n or posedge bus.start) begin
      if (!rst_n) begin
         r_opA     <= 7'd0;
         r_opB     <= 7'd0;
         r_acc     <= 14'd0;
         r_count   <= 3'd0;
         r_product <= 13'd0;
         r_done    <= 1'b0;
      end else if (bus.start) begin
         r_opA     <= bus.a;
         r_opB     <= bus.b;
         r_acc     <= 14'd0;
         r_count   <= 3'd0;
         r_product <= 13'd0;
         r_done    <= 1'b0;
      end else if (w_iterate) begin
         r_acc   <= w_accNext;
         r_count <= r_count + 3'd1;
         if (w_finish) begin
            r_product <= w_accNext[13:1];
            r_done    <= 1'b1;
         end
      end
   end

   assign bus.done    = r_done;
   assign bus.product = r_product;

endmodule

// File: tb/tb_bin_fact.sv
// ----------------------------------------------------------------------------
// tb_bin_fact
// Purpose : Self-checking bench for bin_fact. Expected products are computed
//           from the operands when a run is launched and queued; each test
//           pops and compares them when done rises.
// ----------------------------------------------------------------------------
module tb_bin_fact;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   bin_fact_if bus ();

   bin_fact dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [12:0] expQ[$];

   // Launches a run: operands settle first, then start pulses for 2 ns so
   // it falls between clock edges. The expected product is queued only for
   // runs that are meant to complete.
   task automatic applyStimulus(input logic [6:0] opA, input logic [6:0] opB,
                                input bit push);
      logic [13:0] full;
      @(negedge clk);
      bus.a = opA;
      bus.b = opB;
      if (push) begin
         full = 14'(opA) * 14'(opB);
         expQ.push_back(full[13:1]);
      end
      bus.start = 1'b1;
      #2;
      bus.start = 1'b0;
   endtask

   // Counts rising edges until done, bounded; also records whether any
   // nonzero product appeared before done.
   task automatic waitDone(output int edges, output bit seen, output bit leak);
      edges = 0;
      seen  = 1'b0;
      leak  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.product !== 13'd0) leak = 1'b1;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_done got=%b want=0", bus.done);
      end
      checks++;
      if (bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL reset_product got=%b want=0", bus.product);
      end
      #20 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL reset_idle got done=%b product=%b want 0/0", bus.done, bus.product);
      end
   endtask

   task automatic test_spec_vector();
      int edges; bit seen, leak; logic [12:0] expv, held;
      applyStimulus(7'b1100100, 7'b1101010, 1'b1);
      waitDone(edges, seen, leak);
      checks++;
      if (!seen || edges != 7) begin
         failures++;
         $display("[TB] FAIL spec_latency got edges=%0d seen=%b want 7/1", edges, seen);
      end
      checks++;
      if (leak) begin
         failures++;
         $display("[TB] FAIL spec_busy_product got nonzero want 0");
      end
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL spec_queue got empty want entry");
      end else begin
         expv = expQ.pop_front();
         if (bus.product !== expv) begin
            failures++;
            $display("[TB] FAIL spec_product got=%b want=%b", bus.product, expv);
         end
      end
      checks++;
      if (bus.product !== 13'b1010010110100) begin
         failures++;
         $display("[TB] FAIL spec_const got=%b want=1010010110100", bus.product);
      end
      // Result must hold while operands wander.
      held = bus.product;
      bus.a = 7'h13;
      bus.b = 7'h6E;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b1 || bus.product !== 13'b1010010110100) begin
         failures++;
         $display("[TB] FAIL spec_hold got done=%b product=%b want 1/%b", bus.done, bus.product, held);
      end
   endtask

   task automatic test_max_and_edges();
      int edges; bit seen, leak; logic [12:0] expv;
      logic [6:0] opsA[3] = '{7'h7F, 7'b1000000, 7'h00};
      logic [6:0] opsB[3] = '{7'h7F, 7'b1000000, 7'h55};
      logic [12:0] consts[3] = '{13'b1111110000000, 13'b0100000000000, 13'd0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(opsA[i], opsB[i], 1'b1);
         waitDone(edges, seen, leak);
         checks++;
         if (!seen || edges != 7 || leak) begin
            failures++;
            $display("[TB] FAIL edge_latency[%0d] got edges=%0d seen=%b leak=%b want 7/1/0", i, edges, seen, leak);
         end
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL edge_queue[%0d] got empty want entry", i);
         end else begin
            expv = expQ.pop_front();
            if (bus.product !== expv || expv !== consts[i]) begin
               failures++;
               $display("[TB] FAIL edge_product[%0d] got=%b want=%b", i, bus.product, consts[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      int edges; bit seen, leak; logic [12:0] expv;
      applyStimulus(7'h7F, 7'h7F, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
            failures++;
            $display("[TB] FAIL abort_first got done=%b product=%b want 0/0", bus.done, bus.product);
         end
      end
      applyStimulus(7'b0100000, 7'b0100000, 1'b1);
      waitDone(edges, seen, leak);
      checks++;
      if (!seen || edges != 7 || leak) begin
         failures++;
         $display("[TB] FAIL abort_latency got edges=%0d seen=%b leak=%b want 7/1/0", edges, seen, leak);
      end
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL abort_queue got empty want entry");
      end else begin
         expv = expQ.pop_front();
         if (bus.product !== expv || bus.product !== 13'b0001000000000) begin
            failures++;
            $display("[TB] FAIL abort_product got=%b want=%b", bus.product, expv);
         end
      end
   endtask

   task automatic test_long_start();
      int edges; bit seen, leak; logic [12:0] expv; logic [13:0] full;
      @(negedge clk);
      bus.a = 7'b0110011;
      bus.b = 7'b1010101;
      full = 14'(7'b0110011) * 14'(7'b1010101);
      expQ.push_back(full[13:1]);
      bus.start = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
            failures++;
            $display("[TB] FAIL long_start_hold got done=%b product=%b want 0/0", bus.done, bus.product);
         end
      end
      @(negedge clk);
      #2 bus.start = 1'b0;
      waitDone(edges, seen, leak);
      checks++;
      if (!seen || edges != 7 || leak) begin
         failures++;
         $display("[TB] FAIL long_start_latency got edges=%0d seen=%b leak=%b want 7/1/0", edges, seen, leak);
      end
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL long_start_queue got empty want entry");
      end else begin
         expv = expQ.pop_front();
         if (bus.product !== expv) begin
            failures++;
            $display("[TB] FAIL long_start_product got=%b want=%b", bus.product, expv);
         end
      end
   endtask

   task automatic test_reset_mid();
      int edges; bit seen, leak; logic [12:0] expv;
      // Mid-run reset: outputs are already 0, so also confirm nothing
      // completes afterwards.
      applyStimulus(7'h2A, 7'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid_run got done=%b product=%b want 0/0", bus.done, bus.product);
      end
      #2 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid_run_idle got done=%b product=%b want 0/0", bus.done, bus.product);
      end
      // Mid-DONE reset: clear must happen without waiting for a clock edge.
      applyStimulus(7'h55, 7'h2B, 1'b1);
      waitDone(edges, seen, leak);
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL rst_done_queue got empty want entry");
      end else begin
         expv = expQ.pop_front();
         if (!seen || bus.product !== expv) begin
            failures++;
            $display("[TB] FAIL rst_done_result got=%b seen=%b want=%b", bus.product, seen, expv);
         end
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid_done got done=%b product=%b want 0/0", bus.done, bus.product);
      end
      #1 rst_n = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 13'd0) begin
         failures++;
         $display("[TB] FAIL rst_done_idle got done=%b product=%b want 0/0", bus.done, bus.product);
      end
   endtask

   task automatic test_back_to_back();
      int edges; bit seen, leak; logic [12:0] expv;
      logic [6:0] ra, rb;
      for (int i = 0; i < 6; i++) begin
         ra = 7'($urandom_range(0, 127));
         rb = 7'($urandom_range(0, 127));
         applyStimulus(ra, rb, 1'b1);
         waitDone(edges, seen, leak);
         checks++;
         if (!seen || edges != 7 || leak) begin
            failures++;
            $display("[TB] FAIL b2b_latency[%0d] got edges=%0d seen=%b leak=%b want 7/1/0", i, edges, seen, leak);
         end
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL b2b_queue[%0d] got empty want entry", i);
         end else begin
            expv = expQ.pop_front();
            if (bus.product !== expv) begin
               failures++;
               $display("[TB] FAIL b2b_product[%0d] a=%h b=%h got=%b want=%b", i, ra, rb, bus.product, expv);
            end
         end
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain got=%0d want=0", expQ.size());
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a = 7'd0;
      bus.b = 7'd0;
      test_reset();
      test_spec_vector();
      test_max_and_edges();
      test_abort();
      test_long_start();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
